// File: rtl/rcla_block_serial_sched.sv
// Time-multiplexed 16+64-bit adder: one BLK_W-wide ripple-block carry-lookahead
// slice is driven over NBLK beats, shared round-robin between two requesters.
//
// state | meaning
// IDLE  | waiting for a requester; grants at most one per cycle
// RUN   | one slice beat per cycle, carry chained through carry_q
// DONE  | result presented on out_*, held until out_ready
module rcla_block_serial_sched #(
   parameter int BLK_W = 16,
   parameter int NBLK  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in0_valid,
   output logic                    in0_ready,
   input  logic [BLK_W-1:0]        in0_x,
   input  logic [BLK_W*NBLK-1:0]   in0_y,
   input  logic                    in1_valid,
   output logic                    in1_ready,
   input  logic [BLK_W-1:0]        in1_x,
   input  logic [BLK_W*NBLK-1:0]   in1_y,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [BLK_W*NBLK:0]     out_sum,
   output logic                    out_id,
   output logic                    busy
);

   localparam int CW  = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam int GRP = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [BLK_W-1:0]             x_q;
   logic [NBLK-1:0][BLK_W-1:0]   y_q;
   logic [NBLK-1:0][BLK_W-1:0]   sum_blk_q;
   logic                         sum_msb_q;
   logic                         carry_q;
   logic [CW-1:0]                cnt_q;
   logic                         id_q;
   logic                         prio_q;

   logic                         grant0;
   logic                         grant1;
   logic                         accept;
   logic                         last_beat;

   logic [BLK_W-1:0]             slice_a;
   logic [BLK_W-1:0]             slice_b;
   logic [BLK_W-1:0]             slice_g;
   logic [BLK_W-1:0]             slice_p;
   logic [BLK_W:0]               slice_c;
   logic [BLK_W-1:0]             slice_s;
   logic                         grp_g;
   logic                         grp_p;
   logic                         grp_cin;

   // X is zero-extended, so only block 0 sees a non-zero X operand.
   assign slice_a = (cnt_q == '0) ? x_q : '0;
   assign slice_b = y_q[cnt_q];

   // Lookahead inside each GRP-bit group, rippling group to group.
   always_comb begin
      slice_g    = slice_a & slice_b;
      slice_p    = slice_a ^ slice_b;
      slice_c    = '0;
      slice_c[0] = carry_q;
      grp_g      = 1'b0;
      grp_p      = 1'b1;
      grp_cin    = carry_q;
      for (int i = 0; i < BLK_W; i++) begin
         if ((i % GRP) == 0) begin
            grp_g   = 1'b0;
            grp_p   = 1'b1;
            grp_cin = slice_c[i];
         end
         grp_g        = slice_g[i] | (slice_p[i] & grp_g);
         grp_p        = grp_p & slice_p[i];
         slice_c[i+1] = grp_g | (grp_p & grp_cin);
      end
      slice_s = slice_p ^ slice_c[BLK_W-1:0];
   end

   assign last_beat = (cnt_q == CW'(NBLK - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            grant0 = in0_valid & (~prio_q | ~in1_valid);
            grant1 = in1_valid & (prio_q | ~in0_valid);
            accept = grant0 | grant1;
            if (accept) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last_beat) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q       <= '0;
         y_q       <= '0;
         sum_blk_q <= '0;
         sum_msb_q <= 1'b0;
         carry_q   <= 1'b0;
         cnt_q     <= '0;
         id_q      <= 1'b0;
         prio_q    <= 1'b0;
      end else if (accept) begin
         x_q     <= grant1 ? in1_x : in0_x;
         y_q     <= grant1 ? in1_y : in0_y;
         id_q    <= grant1;
         prio_q  <= ~grant1;
         cnt_q   <= '0;
         carry_q <= 1'b0;
      end else if (state_q == S_RUN) begin
         sum_blk_q[cnt_q] <= slice_s;
         carry_q          <= slice_c[BLK_W];
         cnt_q            <= cnt_q + 1'b1;
         if (last_beat) begin
            sum_msb_q <= slice_c[BLK_W];
         end
      end
   end

   assign in0_ready = grant0;
   assign in1_ready = grant1;
   assign out_valid = (state_q == S_DONE);
   assign out_sum   = {sum_msb_q, sum_blk_q};
   assign out_id    = id_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rcla_block_serial_sched.sv
// Scoreboard bench for rcla_block_serial_sched: directed operations push expected
// {id, sum}; a negedge monitor pops and compares on each output handshake.
module tb_rcla_block_serial_sched;

   logic          clk;
   logic          rst_n;
   logic          in0_valid;
   logic          in0_ready;
   logic [15:0]   in0_x;
   logic [63:0]   in0_y;
   logic          in1_valid;
   logic          in1_ready;
   logic [15:0]   in1_x;
   logic [63:0]   in1_y;
   logic          out_valid;
   logic          out_ready;
   logic [64:0]   out_sum;
   logic          out_id;
   logic          busy;

   typedef struct packed {
      logic        id;
      logic [64:0] sum;
   } exp_t;

   exp_t sb[$];
   int   acc_q[$];
   int   cyc;
   int   checks;
   int   errors;
   logic prev_ov;

   rcla_block_serial_sched #(.BLK_W(16), .NBLK(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_x     (in0_x),
      .in0_y     (in0_y),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_x     (in1_x),
      .in1_y     (in1_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_id    (out_id),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Monitor: ready exclusivity, first-valid latency, handshake compare.
   always @(negedge clk) begin
      exp_t e;
      int   a;
      if (rst_n) begin
         checks++;
         if (in0_ready && in1_ready) begin
            errors++;
            $display("FAIL ready_excl: in0_ready=%0b in1_ready=%0b, required not both 1", in0_ready, in1_ready);
         end
         if (out_valid && !prev_ov) begin
            checks++;
            if (acc_q.size() == 0) begin
               errors++;
               $display("FAIL latency: out_valid rose with no accept outstanding");
            end else begin
               a = acc_q.pop_front();
               if (cyc - a != 4) begin
                  errors++;
                  $display("FAIL latency: got %0d edges, required 4", cyc - a);
               end
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL result: unexpected output sum=%h id=%0b", out_sum, out_id);
            end else begin
               e = sb.pop_front();
               if (out_sum !== e.sum || out_id !== e.id) begin
                  errors++;
                  $display("FAIL result: got sum=%h id=%0b, required sum=%h id=%0b",
                           out_sum, out_id, e.sum, e.id);
               end
            end
         end
         prev_ov = out_valid;
      end else begin
         prev_ov = 1'b0;
      end
   end

   task automatic check(input string name, input logic [64:0] got, input logic [64:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic send(input bit k, input logic [15:0] x, input logic [63:0] y,
                       input bit push, output int waited);
      logic rdy;
      exp_t e;
      if (k) begin in1_valid = 1'b1; in1_x = x; in1_y = y; end
      else   begin in0_valid = 1'b1; in0_x = x; in0_y = y; end
      waited = 0;
      rdy    = 1'b0;
      while (!rdy) begin
         @(negedge clk);
         rdy = k ? in1_ready : in0_ready;
         if (!rdy) begin
            waited++;
            if (waited > 200) begin
               checks++;
               errors++;
               $display("FAIL grant_timeout: requester %0d never granted", k);
               rdy = 1'b1;
            end
         end
      end
      if (waited <= 200) begin
         acc_q.push_back(cyc + 1);
         if (push) begin
            e.id  = k;
            e.sum = 65'(x) + 65'(y);
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
      if (k) in1_valid = 1'b0;
      else   in0_valid = 1'b0;
   endtask

   task automatic wait_out();
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (out_valid) begin
            done = 1'b1;
         end else begin
            check("busy_run", 65'(busy), 65'd1);
            n++;
            if (n > 50) begin
               checks++;
               errors++;
               $display("FAIL out_timeout: out_valid never rose");
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      int   w;
      exp_t e;
      cyc = 0; checks = 0; errors = 0; prev_ov = 1'b0;
      rst_n = 1'b0;
      in0_valid = 1'b0; in0_x = '0; in0_y = '0;
      in1_valid = 1'b0; in1_x = '0; in1_y = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 65'(out_valid), 65'd0);
      check("rst_out_sum", out_sum, 65'd0);
      check("rst_out_id", 65'(out_id), 65'd0);
      check("rst_busy", 65'(busy), 65'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: basic carry out of block 0
      send(1'b0, 16'hFFFF, 64'h1, 1'b1, w);
      check("t1_wait", 65'(w), 65'd0);
      wait_out();
      check("t1_sum", out_sum, 65'h10000);
      @(posedge clk); #1;

      // 2: carry ripples through all four beats
      send(1'b1, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
      wait_out();
      check("t2_sum", out_sum, {1'b1, 64'h0});
      check("t2_id", 65'(out_id), 65'd1);
      @(posedge clk); #1;

      // 3: both requesters contend; strict alternation 0,1,0,1,...
      rst_n = 1'b0; #1;
      sb.delete(); acc_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         e.id = 1'b0; e.sum = 65'd2; sb.push_back(e);
         e.id = 1'b1; e.sum = 65'd4; sb.push_back(e);
      end
      fork
         begin
            int w0;
            for (int i = 0; i < 3; i++) send(1'b0, 16'd1, 64'd1, 1'b0, w0);
         end
         begin
            int w1;
            for (int i = 0; i < 3; i++) send(1'b1, 16'd2, 64'd2, 1'b0, w1);
         end
      join
      drain();
      @(posedge clk); #1;

      // 4: backpressure hold in DONE, then accept right after the handshake
      out_ready = 1'b0;
      send(1'b0, 16'h1234, 64'h10, 1'b1, w);
      wait_out();
      for (int i = 0; i < 10; i++) begin
         check("t4_valid", 65'(out_valid), 65'd1);
         check("t4_sum", out_sum, 65'h1244);
         check("t4_id", 65'(out_id), 65'd0);
         check("t4_ready", 65'({in0_ready, in1_ready}), 65'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(1'b0, 16'd3, 64'd4, 1'b1, w);
      check("t4_reaccept", 65'(w), 65'd1);
      drain();
      @(posedge clk); #1;

      // 5: reset after beat 2 discards the operation and clears carry/prio
      send(1'b0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, w);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      acc_q.delete();
      check("t5_valid", 65'(out_valid), 65'd0);
      check("t5_busy", 65'(busy), 65'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in0_valid = 1'b1; in0_x = 16'h8000; in0_y = 64'h8000;
      in1_valid = 1'b1; in1_x = 16'h0; in1_y = 64'h0;
      @(negedge clk);
      check("t5_prio", 65'({in0_ready, in1_ready}), 65'b10);
      if (in0_ready) begin
         acc_q.push_back(cyc + 1);
         e.id = 1'b0; e.sum = 65'h10000; sb.push_back(e);
      end
      @(posedge clk); #1;
      in0_valid = 1'b0; in1_valid = 1'b0;
      wait_out();
      check("t5_sum", out_sum, 65'h10000);
      @(posedge clk); #1;

      // 6: operand changes after accept are ignored
      send(1'b0, 16'd5, 64'd7, 1'b1, w);
      in0_x = 16'hFFFF; in0_y = 64'h0;
      wait_out();
      check("t6_sum", out_sum, 65'hC);
      drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
